// File: rtl/sha256_round_core_iter_22_3_if.sv
// Bundles the control, chaining-value, W-stream handshake and digest signals of
// the iterative SHA-256 compression core.
interface sha256_round_core_iter_22_3_if;
  logic         start;
  logic         init_sel;
  logic [255:0] h_in;
  logic [31:0]  w_in;
  logic         w_valid;
  logic         w_ready;
  logic         busy;
  logic [255:0] digest;
  logic         digest_valid;

  modport master (
    output start, init_sel, h_in, w_in, w_valid,
    input  w_ready, busy, digest, digest_valid
  );

  modport slave (
    input  start, init_sel, h_in, w_in, w_valid,
    output w_ready, busy, digest, digest_valid
  );
endinterface

// File: rtl/sha256_round_core_iter_22_3.sv
// Iterative SHA-256 compression: one round per accepted schedule word, 64 rounds,
// then the chaining-value add that produces the digest.
//
// state | meaning
// IDLE  | waiting for start; digest holds the last result
// ROUND | accepting W_t, one round per transfer, t counts 0..63
// FINAL | adds chaining value, pulses digest_valid
module sha256_round_core_iter_22_3 #(
  parameter logic [255:0] H_INIT =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input logic                        CLK,
  input logic                        RST,
  sha256_round_core_iter_22_3_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t       state;
  logic [5:0]   t;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  hc [8];
  logic [255:0] src;
  logic [31:0]  s0, s1, ch, maj, t1, t2;

  assign src = bus.init_sel ? bus.h_in : H_INIT;

  always_comb begin
    s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    ch  = (e & f) ^ (~e & g);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t1  = h + s1 + ch + K_ROM[t] + bus.w_in;
    t2  = s0 + maj;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state            <= IDLE;
      t                <= 6'd0;
      {a, b, c, d}     <= '0;
      {e, f, g, h}     <= '0;
      for (int i = 0; i < 8; i++) hc[i] <= 32'h0;
      bus.w_ready      <= 1'b0;
      bus.busy         <= 1'b0;
      bus.digest       <= 256'h0;
      bus.digest_valid <= 1'b0;
    end else begin
      bus.digest_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 8; i++) hc[i] <= src[255 - 32*i -: 32];
            {a, b, c, d, e, f, g, h} <= src;
            t           <= 6'd0;
            state       <= ROUND;
            bus.w_ready <= 1'b1;
            bus.busy    <= 1'b1;
          end
        end
        ROUND: begin
          if (bus.w_valid) begin
            h <= g;
            g <= f;
            f <= e;
            e <= d + t1;
            d <= c;
            c <= b;
            b <= a;
            a <= t1 + t2;
            // 63+1 wraps t to 0, ready for the next block
            t <= t + 6'd1;
            if (t == 6'd63) begin
              state       <= FINAL;
              bus.w_ready <= 1'b0;
            end
          end
        end
        FINAL: begin
          bus.digest <= {hc[0] + a, hc[1] + b, hc[2] + c, hc[3] + d,
                         hc[4] + e, hc[5] + f, hc[6] + g, hc[7] + h};
          bus.digest_valid <= 1'b1;
          bus.busy         <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          state       <= IDLE;
          bus.w_ready <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_core_iter_22_3.sv
// Directed bench for the iterative SHA-256 core: known-answer digests, latency,
// handshake count, stalls, ignored start, back-to-back and async reset.
module tb_sha256_round_core_iter_22_3;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] DBL_DIG =
    256'h4f8b42c2_2dd3729b_519ba6f6_8d2da7cc_5b2d606d_05daed5a_d5128cc0_3e6c6358;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] DBL_BLK   = {ABC_DIG, 32'h80000000, 160'h0, 64'h100};

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  sha256_round_core_iter_22_3_if bus ();

  sha256_round_core_iter_22_3 dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Feeds one block through the core; returns digest, edges from start edge to
  // digest_valid, handshakes, stall cycles and the cycle number of digest_valid.
  task automatic run_block(input logic [511:0] blk, input logic isel, input logic [255:0] hin,
                           input int stall_pct, input int pre_stall, input int inj_round,
                           input int abort_round, output logic [255:0] dig, output int lat,
                           output int hs, output int stalls, output int dv_cyc,
                           output bit aborted);
    logic [31:0]  w [64];
    logic [255:0] dig_before;
    int  idx, n;
    bit  vld, rdy, injected, pre_ok, dv_quiet;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    dig_before = bus.digest;
    idx = 0; n = 0; hs = 0; stalls = 0; lat = 0; dv_cyc = 0;
    aborted = 0; injected = 0; pre_ok = 1;
    bus.start = 1'b1; bus.init_sel = isel; bus.h_in = hin; bus.w_valid = 1'b0;
    @(posedge CLK); #1;
    bus.start = 1'b0; bus.init_sel = ~isel; bus.h_in = ~hin;
    while (1) begin
      vld = (n < pre_stall) ? 1'b0 : ($urandom_range(99) >= stall_pct);
      bus.w_valid = vld;
      bus.w_in = (idx < 64) ? w[idx] : 32'hdeadbeef;
      if (n < pre_stall)
        pre_ok &= (bus.w_ready === 1'b1) && (bus.busy === 1'b1) && (bus.digest === dig_before);
      if (idx == inj_round && !injected) begin
        bus.start = 1'b1; bus.init_sel = 1'b1;
        bus.h_in = 256'h01234567_89abcdef_fedcba98_76543210_0f0f0f0f_f0f0f0f0_55aa55aa_aa55aa55;
        injected = 1;
      end else bus.start = 1'b0;
      if (idx == abort_round) begin
        RST = 1'b0;
        #1;
        check("rst_w_ready", 256'(bus.w_ready), 256'(0));
        check("rst_busy", 256'(bus.busy), 256'(0));
        check("rst_digest_valid", 256'(bus.digest_valid), 256'(0));
        check("rst_digest", bus.digest, 256'h0);
        dv_quiet = 1;
        repeat (3) begin
          @(posedge CLK); #1;
          dv_quiet &= (bus.digest_valid === 1'b0);
        end
        check("rst_no_digest_valid", 256'(dv_quiet), 256'(1));
        RST = 1'b1;
        bus.w_valid = 1'b0;
        aborted = 1;
        break;
      end
      rdy = bus.w_ready;
      @(posedge CLK); #1;
      n++; lat++;
      if (vld && rdy) begin idx++; hs++; end
      else if (rdy) stalls++;
      if (bus.digest_valid === 1'b1) break;
      if (lat > 2000) begin
        check("digest_valid_timeout", 256'(0), 256'(1));
        break;
      end
    end
    bus.start = 1'b0;
    bus.w_valid = 1'b0;
    dig = bus.digest;
    dv_cyc = cyc;
    if (pre_stall > 0) check("stall_hold", 256'(pre_ok), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] dig;
    int lat, hs, stalls, dv1, dv2;
    bit ab;
    bus.start = 1'b0; bus.init_sel = 1'b0; bus.h_in = '0; bus.w_in = '0; bus.w_valid = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_w_ready", 256'(bus.w_ready), 256'(0));
    check("reset_busy", 256'(bus.busy), 256'(0));
    check("reset_digest_valid", 256'(bus.digest_valid), 256'(0));
    check("reset_digest", bus.digest, 256'h0);
    RST = 1'b1;
    @(posedge CLK); #1;

    run_block(ABC_BLK, 1'b0, 256'h0, 0, 0, -1, -1, dig, lat, hs, stalls, dv1, ab);
    check("abc_digest", dig, ABC_DIG);
    check("abc_latency", 256'(lat), 256'(65));
    check("abc_handshakes", 256'(hs), 256'(64));
    @(posedge CLK); #1;
    check("abc_dv_pulse", 256'(bus.digest_valid), 256'(0));
    check("abc_digest_holds", bus.digest, ABC_DIG);

    run_block(ABC_BLK, 1'b0, 256'h0, 0, 100, -1, -1, dig, lat, hs, stalls, dv1, ab);
    check("stall100_digest", dig, ABC_DIG);
    check("stall100_latency", 256'(lat), 256'(165));

    run_block(EMPTY_BLK, 1'b1, IV, 30, 0, -1, -1, dig, lat, hs, stalls, dv1, ab);
    check("empty_digest", dig, EMPTY_DIG);
    check("empty_handshakes", 256'(hs), 256'(64));
    check("empty_latency", 256'(lat), 256'(65 + stalls));

    run_block(DBL_BLK, 1'b0, 256'h0, 0, 0, -1, -1, dig, lat, hs, stalls, dv1, ab);
    check("double_digest", dig, DBL_DIG);

    run_block(ABC_BLK, 1'b0, 256'h0, 0, 0, 20, -1, dig, lat, hs, stalls, dv1, ab);
    check("inj_start_digest", dig, ABC_DIG);
    check("inj_start_latency", 256'(lat), 256'(65));
    run_block(ABC_BLK, 1'b0, 256'h0, 0, 0, -1, -1, dig, lat, hs, stalls, dv2, ab);
    check("b2b_digest", dig, ABC_DIG);
    check("b2b_period", 256'(dv2 - dv1), 256'(66));

    run_block(ABC_BLK, 1'b0, 256'h0, 0, 0, -1, 40, dig, lat, hs, stalls, dv1, ab);
    check("abort_taken", 256'(ab), 256'(1));
    @(posedge CLK); #1;
    run_block(ABC_BLK, 1'b0, 256'h0, 20, 0, -1, -1, dig, lat, hs, stalls, dv1, ab);
    check("post_rst_digest", dig, ABC_DIG);
    check("post_rst_latency", 256'(lat), 256'(65 + stalls));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sha256_round_core_iter_22_3.md
# sha256_round_core_iter_22_3

Iterative SHA-256 compression core: the stage directly downstream of the compact message-schedule window, consuming one schedule word W_t per cycle. It holds the working variables a..h, applies one round per accepted word for 64 rounds, then adds the chaining value and presents the 256-bit digest. A one-word valid/ready handshake on the W stream lets the core stall the schedule window. The core's w_ready drives the window's write_en directly.

## Interface
- H_INIT, 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19, chaining value used when init_sel=0 (SHA-256 IV)
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-low reset
- start  in  1  request a new compression; sampled only in IDLE
- init_sel  in  1  sampled with start: 0 selects H_INIT, 1 selects h_in
- h_in  in  256  external chaining value, {H0..H7}, H0 in [255:224]
- w_in  in  32  schedule word W_t
- w_valid  in  1  w_in is valid this cycle
- w_ready  out  1  core accepts a word this cycle; equals (state==ROUND)
- busy  out  1  high in ROUND and FINAL
- digest  out  256  {H0'..H7'}; holds its value until the next completion
- digest_valid  out  1  one-cycle pulse when digest updates

## Operation
- Internal 64-entry K ROM holds the standard SHA-256 round constants. Registers: a..h, chaining copy H[0..7], 6-bit round counter t, 2-bit state.
- States:
  - IDLE -> ROUND on start. Load H and a..h from the init_sel source. Clear t.
  - ROUND: on each cycle with w_valid=1, perform one round with K[t] and w_in, then t<=t+1.
    - One round: T1=h+Σ1(e)+Ch(e,f,g)+K[t]+W; T2=Σ0(a)+Maj(a,b,c); h<=g; g<=f; f<=e; e<=d+T1; d<=c; c<=b; b<=a; a<=T1+T2.
    - Σ0=ROTR2^ROTR13^ROTR22; Σ1=ROTR6^ROTR11^ROTR25. All additions are mod 2^32.
    - With w_valid=0 the core stalls: no register changes.
    - Acceptance on t=63 -> FINAL.
  - FINAL: digest <= {H0+a, …, H7+h}, per-word mod 2^32. Pulse digest_valid. -> IDLE.
- start outside IDLE is ignored, and init_sel/h_in are not re-sampled.
- w_valid outside ROUND is ignored, since w_ready=0 there.
- t wraps 63->0 only through the FINAL/IDLE path; it never wraps inside ROUND.

## Timing
- Reset values: w_ready=0, busy=0, digest_valid=0, digest=256'h0, state=IDLE, t=0, a..h=0, H=0.
- RST low mid-operation returns to IDLE immediately, asynchronously. The in-flight compression is discarded and no digest_valid is produced.
- Edge E0 samples start. At edge E1+k, round k completes when w_valid is held high. Round 63 completes at E64. digest and digest_valid are registered at E65.
- Minimum latency is 65 cycles from the start edge to digest_valid high. Each stall cycle adds exactly one cycle.
- busy rises after E0 and falls at E65, coincident with digest_valid rising.
- Back-to-back: start may be high in the cycle digest_valid is high, because the core is in IDLE. The new compression begins at the next edge. The period is 66 cycles per block.
- A word transfers only when w_valid and w_ready are both high at a rising edge. Exactly 64 transfers occur per compression.

## Test plan
- "abc", padded single block, init_sel=0, w_valid constant 1:
  - digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
  - digest_valid high exactly 65 cycles after the start edge.
- Empty-string padded block, init_sel=1, h_in=IV, w_valid randomly low 30% of cycles:
  - digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
  - Exactly 64 handshakes occur; latency equals 65 + stall count.
- Double hash: pass the "abc" digest through the compact expander as the second-block source, init_sel=0:
  - digest = 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358.
  - This is SHA256(SHA256("abc")).
- start pulsed at round 20 mid-compression with different h_in: ignored, "abc" digest unchanged. Back-to-back start in the digest_valid cycle yields a second correct digest 66 cycles later.
- RST asserted at round 40:
  - All outputs return to reset values asynchronously, with no digest_valid.
  - The following "abc" run gives the correct digest.
- With w_valid held 0 for 100 cycles after start: t stays 0, w_ready stays 1, busy stays 1, digest is unchanged from the previous value.
